seq_decoder: RTL and testbench
==============================

SEQ_DECODER -- requirements
Module: seq_decoder

Interface
REQ-001 The block SHALL have parameter SEL_W, default 2, meaning select width; legal range 1..6.
REQ-002 The block SHALL have derived constant N_OUT = 2**SEL_W, meaning decoded output count; it is not user-overridable.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port en, input, 1 bit: enable; direct mode gates output, scan mode gates stepping.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 = direct decode, 1 = scan.
REQ-007 The block SHALL have port sel, input, SEL_W bits: select value (direct decode / scan load value).
REQ-008 The block SHALL have port load, input, 1 bit: scan mode, load idx from sel.
REQ-009 The block SHALL have port dir, input, 1 bit: scan direction, 0 = up, 1 = down.
REQ-010 The block SHALL have port d_out, output, N_OUT bits: registered one-hot or all-zero decode.
REQ-011 The block SHALL have port idx_out, output, SEL_W bits: current internal index.
REQ-012 The block SHALL have port valid, output, 1 bit: high when d_out is non-zero.
REQ-013 The block SHALL have port wrap, output, 1 bit: one-cycle pulse on scan wrap-around.

Function
REQ-014 d_out SHALL at all times be all-zero or exactly one bit set; d_out[k] set means index k.
REQ-015 All outputs SHALL be registered; input-to-output latency exactly 1 clock.
REQ-016 Direct mode (mode=0), en=1: next edge idx <= sel, d_out <= one-hot(sel), valid <= 1, wrap <= 0.
REQ-017 Direct mode, en=0: next edge d_out <= 0, valid <= 0, wrap <= 0; idx holds.
REQ-018 Direct mode SHALL ignore load and dir.
REQ-019 Scan mode (mode=1), load=1: next edge idx <= sel, d_out <= one-hot(sel), valid <= 1, wrap <= 0, regardless of en.
REQ-020 Scan mode, load=0, en=1, dir=0: idx <= (idx+1) mod N_OUT, d_out <= one-hot(new idx), valid <= 1.
REQ-021 Scan mode, load=0, en=1, dir=1: idx <= (idx-1) mod N_OUT, d_out <= one-hot(new idx), valid <= 1.
REQ-022 Scan mode, load=0, en=0: idx, d_out, valid hold (pause); wrap <= 0.
REQ-023 wrap SHALL be 1 for exactly the cycle following a step from N_OUT-1 to 0 (up) or from 0 to N_OUT-1 (down); 0 otherwise.
REQ-024 Index arithmetic SHALL be SEL_W-bit modular; no out-of-range index is reachable.
REQ-025 Precedence each edge SHALL be: rst > load (scan) > en step / direct decode > hold.
REQ-026 Mode switch direct->scan SHALL continue from current idx (last direct sel); scan->direct takes effect the same edge per REQ-016/017.
REQ-027 A change of dir SHALL apply from the edge on which it is sampled; no extra latency.
REQ-028 An entry into scan with en=1, load=0 and d_out=0 SHALL step from the held idx and assert valid.

Reset
REQ-029 rst=1 at an edge SHALL set d_out=0, idx_out=0, valid=0, wrap=0, overriding all other inputs.
REQ-030 rst asserted mid-scan SHALL abort scanning; after release with mode=1, en=1, load=0, dir=0 the first step yields idx=1, d_out=one-hot(1).

Verification
REQ-031 SEL_W=2, mode=0, en=1, sel=0,2,1 held 1 cycle each -> d_out 0001, 0100, 0010 one cycle later each; valid=1.
REQ-032 SEL_W=2, mode=0, en=0, sel=3 -> d_out=0000, valid=0, idx_out holds previous value.
REQ-033 SEL_W=2, mode=1, load=1 sel=2, then en=1 dir=0 for 3 cycles -> d_out 0100, 1000, 0001 (wrap=1 this cycle only), 0010.
REQ-034 SEL_W=2, mode=1, load sel=1, en=1 dir=1 for 2 cycles, then en=0 for 2 cycles -> d_out 0010, 0001, 1000 (wrap=1), 1000, 1000 (wrap=0).
REQ-035 Same cycle load=1 and en=1 sel=3 in scan -> d_out=1000, no step, wrap=0; rst=1 during scan -> all outputs 0 next cycle.
REQ-036 SEL_W=3 scan up from load sel=7 -> d_out=0x80 then 0x01 with wrap=1; one-hot/zero assertion checked every cycle across all tests.

Source files
------------

// File: rtl/seq_decoder.sv
// Registered select decoder with a direct-decode mode and an up/down scan mode.
// Outputs are the registered index, its one-hot decode, a valid flag and a wrap pulse.
module seq_decoder #(
    parameter  int SEL_W = 2,
    localparam int N_OUT = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    input  logic             load,
    input  logic             dir,
    output logic [N_OUT-1:0] d_out,
    output logic [SEL_W-1:0] idx_out,
    output logic             valid,
    output logic             wrap
);

    logic [SEL_W-1:0] idx_q;
    logic [SEL_W-1:0] idx_nxt;
    logic [N_OUT-1:0] d_nxt;
    logic             valid_nxt;
    logic             wrap_nxt;

    always_comb begin
        idx_nxt   = idx_q;
        valid_nxt = valid;
        wrap_nxt  = 1'b0;

        if (!mode) begin
            if (en) begin
                idx_nxt   = sel;
                valid_nxt = 1'b1;
            end else begin
                valid_nxt = 1'b0;
            end
        end else if (load) begin
            idx_nxt   = sel;
            valid_nxt = 1'b1;
        end else if (en) begin
            valid_nxt = 1'b1;
            if (!dir) begin
                idx_nxt  = idx_q + SEL_W'(1);
                wrap_nxt = (idx_q == {SEL_W{1'b1}});
            end else begin
                idx_nxt  = idx_q - SEL_W'(1);
                wrap_nxt = (idx_q == '0);
            end
        end

        // d_out always tracks the index it names, or is zero when not valid;
        // this keeps a paused scan and a disabled direct decode consistent.
        d_nxt = '0;
        if (valid_nxt) begin
            d_nxt[idx_nxt] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            d_out <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            idx_q <= idx_nxt;
            d_out <= d_nxt;
            valid <= valid_nxt;
            wrap  <= wrap_nxt;
        end
    end

    assign idx_out = idx_q;

endmodule

// File: tb/tb_seq_decoder.sv
// Bench for seq_decoder: directed vector table, randomized run against a reference
// model, a SEL_W=3 wrap sequence and a continuous one-hot-or-zero check.
module tb_seq_decoder;

    logic       clk = 1'b0;
    logic       rst, en, mode, load, dir;
    logic [1:0] sel;
    logic [3:0] d_out;
    logic [1:0] idx_out;
    logic       valid, wrap;

    logic       rst3, en3, mode3, load3, dir3;
    logic [2:0] sel3;
    logic [7:0] d_out3;
    logic [2:0] idx_out3;
    logic       valid3, wrap3;

    int  vectors = 0;
    int  miscompares = 0;
    bit  chk_on = 1'b0;

    always #5 clk = ~clk;

    seq_decoder #(.SEL_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .load(load), .dir(dir),
        .d_out(d_out), .idx_out(idx_out), .valid(valid), .wrap(wrap)
    );

    seq_decoder #(.SEL_W(3)) dut3 (
        .clk(clk), .rst(rst3), .en(en3), .mode(mode3), .sel(sel3), .load(load3), .dir(dir3),
        .d_out(d_out3), .idx_out(idx_out3), .valid(valid3), .wrap(wrap3)
    );

    typedef struct {
        logic       rst, mode, en, load, dir;
        logic [1:0] sel;
        logic [3:0] d;
        logic [1:0] idx;
        logic       v, w;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, m, e, l, dr, input logic [1:0] s,
                       input logic [3:0] d, input logic [1:0] ix, input logic v, w);
        vec_t t;
        t.rst = r; t.mode = m; t.en = e; t.load = l; t.dir = dr; t.sel = s;
        t.d = d; t.idx = ix; t.v = v; t.w = w;
        tbl.push_back(t);
    endtask

    task automatic check(input string name,
                         input logic [7:0] got_d, input logic [2:0] got_i, input logic got_v, got_w,
                         input logic [7:0] exp_d, input logic [2:0] exp_i, input logic exp_v, exp_w);
        vectors++;
        if (got_d !== exp_d || got_i !== exp_i || got_v !== exp_v || got_w !== exp_w) begin
            miscompares++;
            $display("FAIL %s: got d_out=%h idx=%0d valid=%b wrap=%b, expected d_out=%h idx=%0d valid=%b wrap=%b",
                     name, got_d, got_i, got_v, got_w, exp_d, exp_i, exp_v, exp_w);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            vectors++;
            if (!$onehot0(d_out) || !$onehot0(d_out3)) begin
                miscompares++;
                $display("FAIL onehot0: got d_out=%b d_out3=%b, expected zero or one bit set", d_out, d_out3);
            end
        end
    end

    // Reference model: index as an integer in 0..N-1, decode derived from it.
    int m_idx;
    bit m_valid, m_wrap;

    task automatic model_step(input logic r, m, e, l, dr, input int s, input int n);
        if (r) begin
            m_idx = 0; m_valid = 0; m_wrap = 0;
        end else if (!m) begin
            m_wrap = 0;
            if (e) begin m_idx = s; m_valid = 1; end
            else m_valid = 0;
        end else if (l) begin
            m_idx = s; m_valid = 1; m_wrap = 0;
        end else if (e) begin
            m_valid = 1;
            if (!dr) begin
                m_wrap = (m_idx + 1 == n);
                m_idx  = (m_idx + 1) % n;
            end else begin
                m_wrap = (m_idx == 0);
                m_idx  = (m_idx + n - 1) % n;
            end
        end else begin
            m_wrap = 0;
        end
    endtask

    initial begin
        logic [3:0] exp_d;

        // rst, mode, en, load, dir, sel | d_out, idx, valid, wrap
        add(1,0,0,0,0,0, 4'b0000,0,0,0);
        add(0,0,1,0,0,0, 4'b0001,0,1,0);
        add(0,0,1,0,0,2, 4'b0100,2,1,0);
        add(0,0,1,0,0,1, 4'b0010,1,1,0);
        add(0,0,0,0,0,3, 4'b0000,1,0,0);
        add(0,1,0,1,0,2, 4'b0100,2,1,0);
        add(0,1,1,0,0,0, 4'b1000,3,1,0);
        add(0,1,1,0,0,0, 4'b0001,0,1,1);
        add(0,1,1,0,0,0, 4'b0010,1,1,0);
        add(0,1,0,1,0,1, 4'b0010,1,1,0);
        add(0,1,1,0,1,0, 4'b0001,0,1,0);
        add(0,1,1,0,1,0, 4'b1000,3,1,1);
        add(0,1,0,0,1,0, 4'b1000,3,1,0);
        add(0,1,0,0,1,0, 4'b1000,3,1,0);
        add(0,1,1,1,0,3, 4'b1000,3,1,0);
        add(1,1,1,0,0,2, 4'b0000,0,0,0);
        add(0,1,1,0,0,0, 4'b0010,1,1,0);
        add(0,0,0,0,0,2, 4'b0000,1,0,0);
        add(0,1,1,0,0,0, 4'b0100,2,1,0);
        add(0,0,1,0,0,3, 4'b1000,3,1,0);
        add(0,1,1,0,0,1, 4'b0001,0,1,1);
        add(0,0,1,1,1,2, 4'b0100,2,1,0);
        add(0,1,1,0,1,0, 4'b0010,1,1,0);
        add(0,1,1,0,0,0, 4'b0100,2,1,0);
        add(0,1,0,0,0,1, 4'b0100,2,1,0);
        add(0,0,0,0,0,1, 4'b0000,2,0,0);
        add(0,1,0,0,0,3, 4'b0000,2,0,0);
        add(0,1,1,0,1,0, 4'b0010,1,1,0);

        rst3 = 1; en3 = 0; mode3 = 0; load3 = 0; dir3 = 0; sel3 = 0;

        foreach (tbl[i]) begin
            rst = tbl[i].rst; mode = tbl[i].mode; en = tbl[i].en;
            load = tbl[i].load; dir = tbl[i].dir; sel = tbl[i].sel;
            @(posedge clk); #1;
            chk_on = 1'b1;
            rst3 = 0;
            check($sformatf("table[%0d]", i), {4'b0, d_out}, {1'b0, idx_out}, valid, wrap,
                  {4'b0, tbl[i].d}, {1'b0, tbl[i].idx}, tbl[i].v, tbl[i].w);
        end

        m_idx = 1; m_valid = 1; m_wrap = 0;
        for (int c = 0; c < 400; c++) begin
            rst  = ($urandom_range(31) == 0);
            mode = $urandom_range(1);
            en   = ($urandom_range(3) != 0);
            load = ($urandom_range(7) == 0);
            dir  = $urandom_range(1);
            sel  = 2'($urandom_range(3));
            model_step(rst, mode, en, load, dir, int'(sel), 4);
            @(posedge clk); #1;
            exp_d = m_valid ? 4'(1 << m_idx) : 4'b0;
            check($sformatf("random[%0d]", c), {4'b0, d_out}, {1'b0, idx_out}, valid, wrap,
                  {4'b0, exp_d}, 3'(m_idx), m_valid, m_wrap);
        end

        rst = 0; mode = 1; en = 0; load = 0;
        mode3 = 1; load3 = 1; sel3 = 3'd7; en3 = 0;
        @(posedge clk); #1;
        check("w3_load7", d_out3, idx_out3, valid3, wrap3, 8'h80, 3'd7, 1'b1, 1'b0);
        load3 = 0; en3 = 1; dir3 = 0;
        @(posedge clk); #1;
        check("w3_wrap_up", d_out3, idx_out3, valid3, wrap3, 8'h01, 3'd0, 1'b1, 1'b1);
        @(posedge clk); #1;
        check("w3_after_wrap", d_out3, idx_out3, valid3, wrap3, 8'h02, 3'd1, 1'b1, 1'b0);
        dir3 = 1;
        @(posedge clk); #1;
        check("w3_down", d_out3, idx_out3, valid3, wrap3, 8'h01, 3'd0, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("w3_wrap_down", d_out3, idx_out3, valid3, wrap3, 8'h80, 3'd7, 1'b1, 1'b1);
        rst3 = 1;
        @(posedge clk); #1;
        check("w3_reset", d_out3, idx_out3, valid3, wrap3, 8'h00, 3'd0, 1'b0, 1'b0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
